pixel_stream_tx: RTL and testbench
==================================

Name: pixel_stream_tx

Overview:
- Camera-side byte-stream generator: the transmit end of the HS-gated, two-bytes-per-pixel camera interface used by the pixel capture path.
- Accepts 16-bit pixels over a valid/ready handshake and emits Out_Data/HS/VS/PCLK with fixed line and frame timing.
- Used as an on-board camera emulator for loopback bring-up and as a stimulus source for the convolution engine benches.

Parameters:
- H_ACTIVE, 640: pixels per active line. Each pixel takes 2 byte slots.
- H_BLANK, 144: byte slots with HS=0 after each line.
- V_SYNC, 3: lines with VS=1 at frame start.
- V_ACTIVE, 480: active lines per frame.
- V_BLANK, 10: blank lines at frame end.
- BYTE_CYC, 5: clk_50M cycles per byte slot. Must be ≥2. Default gives a 10 MHz byte rate.

Ports:
- clk_50M  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- En  in  1  frame enable; sampled only in IDLE and at end of frame.
- Pixel_In  in  16  pixel word; low byte is transmitted first.
- Pix_Valid  in  1  Pixel_In is valid.
- Pix_Ready  out  1  module takes a pixel this cycle if Pix_Valid=1.
- Out_Data  out  8  byte bus; changes only on the first cycle of a slot.
- HS  out  1  line valid; 1 during active byte slots.
- VS  out  1  frame sync; 1 during V_SYNC lines.
- PCLK  out  1  byte clock; 0 for the first BYTE_CYC/2 cycles of a slot (floor), then 1.
- Frame_Done  out  1  one-cycle pulse at end of frame.
- Underrun  out  1  sticky: a pixel was needed while Pix_Valid=0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters 0, hold register 0. Outputs: Out_Data=0, HS=0, VS=0, PCLK=0, Pix_Ready=0, Frame_Done=0, Underrun=0.
- Counters:
  - slot_cnt runs 0..BYTE_CYC-1 whenever state≠IDLE.
  - byte_cnt counts byte slots within a line (0..2*H_ACTIVE+H_BLANK-1).
  - line_cnt counts lines within a frame (0..V_SYNC+V_ACTIVE+V_BLANK-1).
- States:
  - IDLE: all outputs 0 and PCLK held 0. When En=1, go to SYNC with all counters cleared. Underrun is cleared on this transition.
  - SYNC: runs for V_SYNC full lines. VS=1, HS=0, Out_Data=0. Then go to ACTIVE.
  - ACTIVE: runs for V_ACTIVE lines.
    - Slots 0..2*H_ACTIVE-1 have HS=1. Even slot = low byte, odd slot = high byte.
    - The remaining H_BLANK slots have HS=0 and Out_Data=0.
    - Then go to BLANK.
  - BLANK: runs for V_BLANK lines with HS=0, VS=0, Out_Data=0.
    - On the last cycle, Frame_Done=1 for one cycle.
    - Next state is SYNC if En=1, else IDLE.
- Pixel fetch:
  - Pix_Ready=1 only on cycle slot_cnt=BYTE_CYC-1 of the slot before each even active slot. For pixel 0, that is the last cycle of the preceding blank/sync slot.
  - On that edge, if Pix_Valid=1: hold<=Pixel_In and Out_Data<=Pixel_In[7:0].
  - If Pix_Valid=0 on that edge: hold<=0, Out_Data<=0, Underrun<=1. Line timing never stalls.
  - On the edge entering an odd slot: Out_Data<=hold[15:8].
  - Pixel latency: Pixel_In[7:0] appears on Out_Data 1 cycle after the handshake. The high byte appears BYTE_CYC cycles later.
- HS and VS change on the same edge as Out_Data (slot boundary, while PCLK=0). This guarantees setup time before the PCLK rise.
- En is ignored mid-frame. Deasserting En always finishes the current frame.
- Simultaneous events: the end of a line and the end of a frame are evaluated on the same edge. The last H_BLANK slot of the last line goes directly to the next state with no extra cycle.
- Reset mid-frame returns to IDLE immediately, with all outputs 0 in the same cycle. Partial pixels are discarded.
- Widths: counters are sized with $clog2 of their terminal value plus 1. No arithmetic wraps except at the defined terminals.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=3, V_SYNC=1, V_ACTIVE=2, V_BLANK=1, BYTE_CYC=4. A line is 11 slots (44 cycles); a frame is 176 cycles.
- Reset during ACTIVE with HS=1 → HS, VS, PCLK, Out_Data, Pix_Ready all 0 asynchronously. After release: state stays IDLE while En=0.
- En=1, pixels 0x1122,0x3344,0x5566,0x7788 always valid → 44 cycles of VS=1, then HS=1 for 8 slots. Bytes sampled on PCLK rise: 22,11,44,33,66,55,88,77. Then HS=0 for 3 slots.
- Full frame with continuous En=1 → exactly 8 Pix_Ready pulses per frame. Frame_Done pulses at cycle 175. VS rises again at cycle 176.
- Pix_Valid=0 for the 3rd pixel only → that pixel's two bytes are 00,00. Underrun=1 and stays 1 to end of frame. The next pixel is transmitted correctly.
- Deassert En mid-ACTIVE → frame completes with all 8 pixels. Frame_Done pulses, then IDLE with PCLK=0.
- Set BYTE_CYC=2 → PCLK toggles every cycle. Out_Data changes only while PCLK=0. Same byte order as the 2nd scenario.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// Camera-side byte-stream generator: 16-bit pixels in over valid/ready, out as an
// HS/VS-gated byte bus with a divided PCLK and fixed line/frame timing.
module pixel_stream_tx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BLANK  = 10,
  parameter int unsigned BYTE_CYC = 5
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        En,
  input  logic [15:0] Pixel_In,
  input  logic        Pix_Valid,
  output logic        Pix_Ready,
  output logic [7:0]  Out_Data,
  output logic        HS,
  output logic        VS,
  output logic        PCLK,
  output logic        Frame_Done,
  output logic        Underrun
);

  localparam int unsigned ACT_SLOTS   = 2 * H_ACTIVE;
  localparam int unsigned LINE_SLOTS  = ACT_SLOTS + H_BLANK;
  localparam int unsigned FRAME_LINES = V_SYNC + V_ACTIVE + V_BLANK;
  localparam int unsigned PCLK_LOW    = BYTE_CYC / 2;

  localparam int unsigned SLOT_W = $clog2(BYTE_CYC) + 1;
  localparam int unsigned BYTE_W = $clog2(LINE_SLOTS) + 1;
  localparam int unsigned LINE_W = $clog2(FRAME_LINES) + 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(BYTE_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_RISE  = SLOT_W'(PCLK_LOW);
  localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(LINE_SLOTS - 1);
  localparam logic [BYTE_W-1:0] BYTE_ACT   = BYTE_W'(ACT_SLOTS);
  localparam logic [BYTE_W-1:0] BYTE_ACT_L = BYTE_W'(ACT_SLOTS - 1);
  localparam logic [LINE_W-1:0] LINE_SYNC  = LINE_W'(V_SYNC - 1);
  localparam logic [LINE_W-1:0] LINE_ACT_F = LINE_W'(V_SYNC);
  localparam logic [LINE_W-1:0] LINE_ACT_L = LINE_W'(V_SYNC + V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [15:0]       hold_q, hold_d;
  logic              underrun_q, underrun_d;
  logic              end_slot, end_line;

  logic [7:0]        data_q, data_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              pclk_q, pclk_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              running_d, line_act_d, pre_act_d;
  logic [LINE_W-1:0] line_nx_d;

  // Sequencer: slot/byte/line counters and frame state
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    byte_d     = byte_q;
    line_d     = line_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    end_slot   = (slot_q == SLOT_LAST);
    end_line   = end_slot && (byte_q == BYTE_LAST);

    case (state_q)
      ST_IDLE: begin
        slot_d = '0;
        byte_d = '0;
        line_d = '0;
        if (En) begin
          state_d    = ST_SYNC;
          underrun_d = 1'b0;
        end
      end
      default: begin
        slot_d = end_slot ? '0 : slot_q + SLOT_W'(1);
        if (end_slot) begin
          byte_d = (byte_q == BYTE_LAST) ? '0 : byte_q + BYTE_W'(1);
        end
        if (end_line) begin
          line_d = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
          case (state_q)
            ST_SYNC:   if (line_q == LINE_SYNC)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (line_q == LINE_ACT_L) state_d = ST_BLANK;
            ST_BLANK:  if (line_q == LINE_LAST)  state_d = En ? ST_SYNC : ST_IDLE;
            default:   state_d = state_q;
          endcase
        end
      end
    endcase

    // Pixel handshake completes on the edge ending a Pix_Ready cycle; timing never stalls
    if (rdy_q) begin
      hold_d = Pix_Valid ? Pixel_In : 16'h0000;
      if (!Pix_Valid) begin
        underrun_d = 1'b1;
      end
    end
  end

  // Output values for the upcoming cycle, derived from the next counter state
  always_comb begin
    running_d  = (state_d != ST_IDLE);
    line_nx_d  = line_d + LINE_W'(1);
    line_act_d = (line_d >= LINE_ACT_F) && (line_d <= LINE_ACT_L);
    pre_act_d  = (line_nx_d >= LINE_ACT_F) && (line_nx_d <= LINE_ACT_L);
    hs_d       = (state_d == ST_ACTIVE) && (byte_d < BYTE_ACT);
    vs_d       = (state_d == ST_SYNC);
    pclk_d     = running_d && (slot_d >= SLOT_RISE);
    rdy_d      = running_d && (slot_d == SLOT_LAST) &&
                 ((line_act_d && byte_d[0] && (byte_d < BYTE_ACT_L)) ||
                  (pre_act_d && (byte_d == BYTE_LAST)));
    done_d     = (state_d == ST_BLANK) && (slot_d == SLOT_LAST) &&
                 (byte_d == BYTE_LAST) && (line_d == LINE_LAST);

    data_d = 8'h00;
    if (running_d) begin
      if (slot_d != '0) begin
        data_d = data_q;
      end else if (hs_d) begin
        if (byte_d[0]) begin
          data_d = hold_q[15:8];
        end else begin
          data_d = (rdy_q && Pix_Valid) ? Pixel_In[7:0] : 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      byte_q     <= '0;
      line_q     <= '0;
      hold_q     <= 16'h0000;
      underrun_q <= 1'b0;
      data_q     <= 8'h00;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      pclk_q     <= 1'b0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      byte_q     <= byte_d;
      line_q     <= line_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      data_q     <= data_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      pclk_q     <= pclk_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
    end
  end

  assign Pix_Ready  = rdy_q;
  assign Out_Data   = data_q;
  assign HS         = hs_q;
  assign VS         = vs_q;
  assign PCLK       = pclk_q;
  assign Frame_Done = done_q;
  assign Underrun   = underrun_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx with a reduced frame (4x2 active, 11-slot lines),
// plus a second instance at two cycles per byte slot.
module tb_pixel_stream_tx;

  logic clk;
  logic rst;

  logic        En1, Pix_Valid1, Pix_Ready1, HS1, VS1, PCLK1, Frame_Done1, Underrun1;
  logic [15:0] Pixel_In1;
  logic [7:0]  Out_Data1;
  logic        En2, Pix_Valid2, Pix_Ready2, HS2, VS2, PCLK2, Frame_Done2, Underrun2;
  logic [15:0] Pixel_In2;
  logic [7:0]  Out_Data2;

  logic [15:0] pix_tab [8];
  logic [2:0]  idx1, idx2;
  logic        drop_en;

  int n_run;
  int n_fail;

  logic       c_hs   [200];
  logic       c_vs   [200];
  logic       c_pclk [200];
  logic       c_rdy  [200];
  logic       c_done [200];
  logic       c_und  [200];
  logic [7:0] c_data [200];
  logic [7:0] got_q [$];
  logic [7:0] exp_bytes [16];

  typedef struct {
    int          cyc;
    logic [12:0] exp;  // {hs, vs, pclk, data[7:0], rdy, done}
  } vec_t;
  vec_t vecs [24];

  pixel_stream_tx #(
    .H_ACTIVE(4), .H_BLANK(3), .V_SYNC(1), .V_ACTIVE(2), .V_BLANK(1), .BYTE_CYC(4)
  ) dut1 (
    .clk_50M(clk), .rst(rst), .En(En1), .Pixel_In(Pixel_In1), .Pix_Valid(Pix_Valid1),
    .Pix_Ready(Pix_Ready1), .Out_Data(Out_Data1), .HS(HS1), .VS(VS1), .PCLK(PCLK1),
    .Frame_Done(Frame_Done1), .Underrun(Underrun1)
  );

  pixel_stream_tx #(
    .H_ACTIVE(4), .H_BLANK(3), .V_SYNC(1), .V_ACTIVE(2), .V_BLANK(1), .BYTE_CYC(2)
  ) dut2 (
    .clk_50M(clk), .rst(rst), .En(En2), .Pixel_In(Pixel_In2), .Pix_Valid(Pix_Valid2),
    .Pix_Ready(Pix_Ready2), .Out_Data(Out_Data2), .HS(HS2), .VS(VS2), .PCLK(PCLK2),
    .Frame_Done(Frame_Done2), .Underrun(Underrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel sources: step through the table on every Pix_Ready, optionally withholding entry 2
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx1 <= 3'd0;
      idx2 <= 3'd0;
    end else begin
      if (Pix_Ready1) idx1 <= idx1 + 3'd1;
      if (Pix_Ready2) idx2 <= idx2 + 3'd1;
    end
  end
  assign Pixel_In1  = pix_tab[idx1];
  assign Pix_Valid1 = !(drop_en && (idx1 == 3'd2));
  assign Pixel_In2  = pix_tab[idx2];
  assign Pix_Valid2 = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int c, input logic [12:0] e);
    vec_t v;
    v.cyc = c;
    v.exp = e;
    return v;
  endfunction

  // Sample n cycles at negedge; drop the selected instance's En after sample off_at
  task automatic capture(input int n, input bit sel, input int off_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!sel) begin
        c_hs[k] = HS1; c_vs[k] = VS1; c_pclk[k] = PCLK1; c_rdy[k] = Pix_Ready1;
        c_done[k] = Frame_Done1; c_und[k] = Underrun1; c_data[k] = Out_Data1;
        if (k == off_at) En1 = 1'b0;
      end else begin
        c_hs[k] = HS2; c_vs[k] = VS2; c_pclk[k] = PCLK2; c_rdy[k] = Pix_Ready2;
        c_done[k] = Frame_Done2; c_und[k] = Underrun2; c_data[k] = Out_Data2;
        if (k == off_at) En2 = 1'b0;
      end
    end
  endtask

  // Bytes latched by a sink on PCLK rise while HS=1
  task automatic get_bytes(input int n);
    got_q.delete();
    for (int k = 1; k < n; k++) begin
      if (c_pclk[k] && !c_pclk[k-1] && c_hs[k]) got_q.push_back(c_data[k]);
    end
  endtask

  task automatic chk_bytes(input string tag, input int drop_at);
    logic [7:0] e;
    chk($sformatf("%s_nbytes", tag), 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      e = (i == drop_at || i == drop_at + 1) ? 8'h00 : exp_bytes[i];
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(e));
    end
  endtask

  task automatic chk_stable(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 1; k < n; k++) begin
      if (c_data[k] != c_data[k-1] && c_pclk[k]) bad++;
    end
    chk($sformatf("%s_data_while_pclk_hi", tag), 32'(bad), 32'd0);
  endtask

  function automatic int count_rdy(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (c_rdy[k]) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (c_done[k]) c++;
    return c;
  endfunction

  initial begin
    int bad;
    n_run = 0;
    n_fail = 0;
    pix_tab[0] = 16'h1122; pix_tab[1] = 16'h3344; pix_tab[2] = 16'h5566; pix_tab[3] = 16'h7788;
    pix_tab[4] = 16'h99AA; pix_tab[5] = 16'hBBCC; pix_tab[6] = 16'hDDEE; pix_tab[7] = 16'hF001;
    exp_bytes = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77,
                  8'hAA, 8'h99, 8'hCC, 8'hBB, 8'hEE, 8'hDD, 8'h01, 8'hF0};

    vecs[0]  = mkv(0,   {3'b010, 8'h00, 2'b00});
    vecs[1]  = mkv(2,   {3'b011, 8'h00, 2'b00});
    vecs[2]  = mkv(43,  {3'b011, 8'h00, 2'b10});
    vecs[3]  = mkv(44,  {3'b100, 8'h22, 2'b00});
    vecs[4]  = mkv(46,  {3'b101, 8'h22, 2'b00});
    vecs[5]  = mkv(49,  {3'b100, 8'h11, 2'b00});
    vecs[6]  = mkv(51,  {3'b101, 8'h11, 2'b10});
    vecs[7]  = mkv(52,  {3'b100, 8'h44, 2'b00});
    vecs[8]  = mkv(56,  {3'b100, 8'h33, 2'b00});
    vecs[9]  = mkv(59,  {3'b101, 8'h33, 2'b10});
    vecs[10] = mkv(60,  {3'b100, 8'h66, 2'b00});
    vecs[11] = mkv(64,  {3'b100, 8'h55, 2'b00});
    vecs[12] = mkv(67,  {3'b101, 8'h55, 2'b10});
    vecs[13] = mkv(68,  {3'b100, 8'h88, 2'b00});
    vecs[14] = mkv(75,  {3'b101, 8'h77, 2'b00});
    vecs[15] = mkv(76,  {3'b000, 8'h00, 2'b00});
    vecs[16] = mkv(87,  {3'b001, 8'h00, 2'b10});
    vecs[17] = mkv(88,  {3'b100, 8'hAA, 2'b00});
    vecs[18] = mkv(116, {3'b100, 8'hF0, 2'b00});
    vecs[19] = mkv(119, {3'b101, 8'hF0, 2'b00});
    vecs[20] = mkv(120, {3'b000, 8'h00, 2'b00});
    vecs[21] = mkv(132, {3'b000, 8'h00, 2'b00});
    vecs[22] = mkv(174, {3'b001, 8'h00, 2'b00});
    vecs[23] = mkv(175, {3'b001, 8'h00, 2'b01});

    rst = 1'b0; En1 = 1'b0; En2 = 1'b0; drop_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        32'({HS1, VS1, PCLK1, Out_Data1, Pix_Ready1, Frame_Done1, Underrun1}), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_en0", 32'({HS1, VS1, PCLK1, Out_Data1, Pix_Ready1}), 32'd0);

    // Asynchronous reset while HS is high
    En1 = 1'b1;
    repeat (47) @(negedge clk);
    chk("pre_reset_hs", 32'(HS1), 32'd1);
    #2 rst = 1'b0; En1 = 1'b0;
    #1 chk("async_reset_outputs", 32'({HS1, VS1, PCLK1, Out_Data1, Pix_Ready1}), 32'd0);
    @(negedge clk) rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (HS1 || VS1 || PCLK1 || Pix_Ready1) bad++;
    end
    chk("post_reset_stays_idle", 32'(bad), 32'd0);

    // Frame 1: En held high, every pixel valid
    En1 = 1'b1;
    capture(176, 1'b0, -1);
    foreach (vecs[i]) begin
      chk($sformatf("vec_cyc%0d", vecs[i].cyc),
          32'({c_hs[vecs[i].cyc], c_vs[vecs[i].cyc], c_pclk[vecs[i].cyc],
               c_data[vecs[i].cyc], c_rdy[vecs[i].cyc], c_done[vecs[i].cyc]}),
          32'(vecs[i].exp));
    end
    chk("f1_ready_pulses", 32'(count_rdy(176)), 32'd8);
    chk("f1_done_pulses", 32'(count_done(176)), 32'd1);
    chk("f1_underrun", 32'(c_und[175]), 32'd0);
    get_bytes(176);
    chk_bytes("f1", -2);
    chk_stable("f1", 176);

    // Frame 2: back-to-back, third pixel withheld, En dropped mid-active
    drop_en = 1'b1;
    capture(180, 1'b0, 70);
    drop_en = 1'b0;
    chk("f2_vs_restart", 32'(c_vs[0]), 32'd1);
    chk("f2_underrun_before", 32'(c_und[59]), 32'd0);
    chk("f2_underrun_set", 32'(c_und[60]), 32'd1);
    chk("f2_underrun_sticky", 32'(c_und[175]), 32'd1);
    chk("f2_ready_pulses", 32'(count_rdy(180)), 32'd8);
    chk("f2_done_last", 32'(c_done[175]), 32'd1);
    chk("f2_done_pulses", 32'(count_done(180)), 32'd1);
    chk("f2_idle_176", 32'({c_hs[176], c_vs[176], c_pclk[176], c_data[176], c_rdy[176]}), 32'd0);
    chk("f2_idle_179", 32'({c_hs[179], c_vs[179], c_pclk[179], c_data[179], c_rdy[179]}), 32'd0);
    chk("f2_underrun_idle", 32'(c_und[179]), 32'd1);
    get_bytes(180);
    chk_bytes("f2", 4);

    // Re-enable clears the sticky underrun
    En1 = 1'b1;
    @(negedge clk);
    En1 = 1'b0;
    chk("reenable_underrun_clr", 32'({Underrun1, VS1}), 32'b01);

    // Two cycles per slot: PCLK toggles every cycle
    En2 = 1'b1;
    capture(90, 1'b1, 3);
    bad = 0;
    for (int k = 0; k < 88; k++) if (c_pclk[k] !== 1'(k & 1)) bad++;
    chk("bc2_pclk_toggle", 32'(bad), 32'd0);
    chk("bc2_ready_pulses", 32'(count_rdy(90)), 32'd8);
    chk("bc2_done_last", 32'(c_done[87]), 32'd1);
    chk("bc2_idle", 32'({c_vs[89], c_pclk[89], c_hs[89]}), 32'd0);
    get_bytes(90);
    chk_bytes("bc2", -2);
    chk_stable("bc2", 90);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
